// File: rtl/mul8_shift_add_pkg.sv
// Shared definitions for the execution-unit sequencers (MUL now, DIV later).
//   state_t   : sequencer state encoding (idle / iterate / final fix-up)
//   ITER_LAST : value of the 3-bit iteration counter on the last iteration
package mul8_shift_add_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    localparam logic [2:0] ITER_LAST = 3'd7;

endpackage

// File: rtl/adder.sv
// 8-bit adder without carry-in, shared with the ALU data path.
//   A, B : addends
//   Sum  : low 8 bits of A+B
//   Cout : carry out of bit 7
module adder (
    input  logic [7:0] A,
    input  logic [7:0] B,
    output logic [7:0] Sum,
    output logic       Cout
);

    assign {Cout, Sum} = {1'b0, A} + {1'b0, B};

endmodule

// File: rtl/mul8_shift_add.sv
// Sequential 8x8 -> 16 multiplier (8086 byte MUL / IMUL), radix-2
// shift-and-add, one iteration per clock.  Signed operands are reduced to
// magnitudes on capture, and the sign is restored in the final FIX cycle.
//   clk, rst   : clock, synchronous active-high reset
//   start      : request, accepted only while busy=0
//   is_signed  : 1 = IMUL, 0 = MUL (sampled with start)
//   A, B       : multiplicand / multiplier (sampled with start)
//   product    : AH:AL result, held until the next completion
//   busy       : operation in progress
//   done       : one-cycle completion pulse
//   cf_of      : CF/OF value of the completed operation
module mul8_shift_add
    import mul8_shift_add_pkg::*;
#(
    parameter int ITER = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        is_signed,
    input  logic [7:0]  A,
    input  logic [7:0]  B,
    output logic [15:0] product,
    output logic        busy,
    output logic        done,
    output logic        cf_of
);

    state_t          state, state_nxt;
    logic [ITER-1:0] hi, mcand, mplr;
    logic [2:0]      cnt;
    logic            sgn, is_signed_q;

    logic [7:0]      add_b, add_sum;
    logic            add_cout;
    logic [15:0]     mag, prod_nxt;
    logic            cf_nxt;

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start)            state_nxt = ST_RUN;
            ST_RUN:  if (cnt == ITER_LAST) state_nxt = ST_FIX;
            ST_FIX:                        state_nxt = ST_IDLE;
            default:                       state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // FIX is still busy; the done cycle (first IDLE) is not.
    assign busy = (state != ST_IDLE);

    // Partial-product add: hi + (mplr[0] ? mcand : 0)
    assign add_b = mplr[0] ? mcand : 8'h00;

    adder u_adder (
        .A    (hi),
        .B    (add_b),
        .Sum  (add_sum),
        .Cout (add_cout)
    );

    // Sign restore and overflow flag, used only in FIX.
    assign mag      = {hi, mplr};
    assign prod_nxt = sgn ? (~mag + 16'd1) : mag;
    assign cf_nxt   = is_signed_q ? (prod_nxt[15:8] != {8{prod_nxt[7]}})
                                  : (|prod_nxt[15:8]);

    always_ff @(posedge clk) begin
        if (rst) begin
            hi          <= '0;
            mcand       <= '0;
            mplr        <= '0;
            cnt         <= '0;
            sgn         <= 1'b0;
            is_signed_q <= 1'b0;
            product     <= '0;
            cf_of       <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        // -128 negates to 0x80, which is the correct
                        // unsigned magnitude.
                        sgn         <= is_signed & (A[7] ^ B[7]);
                        is_signed_q <= is_signed;
                        mcand       <= (is_signed & A[7]) ? (~A + 8'd1) : A;
                        mplr        <= (is_signed & B[7]) ? (~B + 8'd1) : B;
                        hi          <= '0;
                        cnt         <= '0;
                    end
                end
                ST_RUN: begin
                    // 17-bit {Cout,Sum,mplr} shifted right by one; the
                    // consumed multiplier bit drops out of the bottom.
                    {hi, mplr} <= {add_cout, add_sum, mplr[7:1]};
                    cnt        <= cnt + 3'd1;
                end
                ST_FIX: begin
                    product <= prod_nxt;
                    cf_of   <= cf_nxt;
                    done    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul8_shift_add.sv
module tb_mul8_shift_add;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        is_signed;
    logic [7:0]  A, B;
    logic [15:0] product;
    logic        busy, done, cf_of;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [15:0] last_p;
    logic        last_cf;

    mul8_shift_add #(.ITER(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .is_signed (is_signed),
        .A         (A),
        .B         (B),
        .product   (product),
        .busy      (busy),
        .done      (done),
        .cf_of     (cf_of)
    );

    always #5 clk = ~clk;

    // Reference: plain integer multiply, flag from result range.
    function automatic logic [16:0] ref_mul(input logic [7:0] a, input logic [7:0] b,
                                            input logic s);
        int   p;
        logic cf;
        if (s) begin
            p  = int'($signed(a)) * int'($signed(b));
            cf = (p > 127) || (p < -128);
        end else begin
            p  = int'(a) * int'(b);
            cf = (p > 255);
        end
        return {cf, p[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Called at the negedge of cycle t; returns at the negedge of the done
    // cycle t+10 with start low.  pulse_k > 0 re-pulses start during busy.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic s,
                          input int pulse_k);
        logic [16:0] e;
        e         = ref_mul(a, b, s);
        A         = a;
        B         = b;
        is_signed = s;
        start     = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            start     = (k == pulse_k);
            A         = 8'($urandom);
            B         = 8'($urandom);
            is_signed = 1'($urandom);
            chk($sformatf("busy_t+%0d", k), 16'(busy), 16'd1);
            chk($sformatf("nodone_t+%0d", k), 16'(done), 16'd0);
            chk($sformatf("hold_t+%0d", k), product, last_p);
        end
        @(negedge clk);
        start = 1'b0;
        chk("done_t+10", 16'(done), 16'd1);
        chk("busy_t+10", 16'(busy), 16'd0);
        chk($sformatf("prod_%h*%h_s%0d", a, b, s), product, e[15:0]);
        chk($sformatf("cf_%h*%h_s%0d", a, b, s), 16'(cf_of), 16'(e[16]));
        last_p  = e[15:0];
        last_cf = e[16];
    endtask

    initial begin
        logic [16:0] e;
        logic [7:0]  ra, rb;
        rst = 1'b1; start = 1'b0; is_signed = 1'b0; A = '0; B = '0;
        last_p = '0; last_cf = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_product", product, 16'h0000);
        chk("rst_busy", 16'(busy), 16'd0);
        chk("rst_done", 16'(done), 16'd0);
        chk("rst_cf", 16'(cf_of), 16'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed cases, back to back (each start lands in the done cycle)
        run_op(8'hFF, 8'hFF, 1'b0, 0);
        chk("ff_ff_abs", product, 16'hFE01);
        run_op(8'h0C, 8'h0A, 1'b0, 0);
        chk("0c_0a_abs", product, 16'h0078);
        run_op(8'h00, 8'hB7, 1'b0, 0);
        run_op(8'h80, 8'h80, 1'b1, 0);
        chk("s80_80_abs", product, 16'h4000);
        run_op(8'hFF, 8'h05, 1'b1, 0);
        chk("sff_05_abs", product, 16'hFFFB);
        run_op(8'h80, 8'h01, 1'b1, 0);
        run_op(8'h40, 8'h02, 1'b1, 0);
        chk("s40_02_cf", 16'(cf_of), 16'd1);

        // Start re-pulsed at t+3 is ignored
        run_op(8'h37, 8'h59, 1'b0, 3);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("ignored_start_nodone", 16'(done), 16'd0);
            chk("ignored_start_hold", product, last_p);
        end

        // Randomized operations with a reset-free gap of idle cycles
        for (int i = 0; i < 24; i++) begin
            run_op(8'($urandom), 8'($urandom), 1'($urandom), 0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Reset in the middle of an operation
        A = 8'hA5; B = 8'h5A; is_signed = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", 16'(busy), 16'd0);
        chk("midrst_done", 16'(done), 16'd0);
        chk("midrst_product", product, 16'h0000);
        chk("midrst_cf", 16'(cf_of), 16'd0);
        last_p = '0; last_cf = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            chk("midrst_nodone", 16'(done), 16'd0);
        end
        run_op(8'h12, 8'h34, 1'b0, 0);
        chk("12_34_abs", product, 16'h03A8);

        // start held high: one operation every 10 cycles
        @(negedge clk);
        ra = 8'h9C; rb = 8'hE3;
        A = ra; B = rb; is_signed = 1'b1; start = 1'b1;
        for (int r = 0; r < 3; r++) begin
            e = ref_mul(ra, rb, is_signed);
            for (int k = 1; k <= 9; k++) begin
                @(negedge clk);
                A = 8'($urandom); B = 8'($urandom);
                chk("held_nodone", 16'(done), 16'd0);
                chk("held_hold", product, last_p);
            end
            @(negedge clk);
            chk("held_done", 16'(done), 16'd1);
            chk("held_prod", product, e[15:0]);
            chk("held_cf", 16'(cf_of), 16'(e[16]));
            last_p = e[15:0];
            ra = 8'($urandom); rb = 8'($urandom);
            A = ra; B = rb;
            is_signed = (r == 0) ? 1'b0 : 1'b1;
        end
        start = 1'b0;
        repeat (12) @(negedge clk);
        chk("final_hold", product, last_p);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
